// File: rtl/simplebus_arb.sv
// simplebus_arb: two-requester arbiter onto one shared request/response bus, one transaction outstanding
// Ports: clk, rst (async, active high); in{0,1}_req_* requester request channels (valid/ready + addr/size/cmd/wmask/wdata/user);
// in{0,1}_resp_* response channels back to each requester (valid/ready + cmd/rdata/user);
// out_req_* request channel to the shared bus; out_resp_* response channel from the shared bus.
// ARB_MODE: 0 round robin, 1 fixed priority with in0 highest.
module simplebus_arb #(
    parameter int ARB_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in0_req_valid,
    output logic        in0_req_ready,
    input  logic [31:0] in0_req_bits_addr,
    input  logic [2:0]  in0_req_bits_size,
    input  logic [3:0]  in0_req_bits_cmd,
    input  logic [7:0]  in0_req_bits_wmask,
    input  logic [63:0] in0_req_bits_wdata,
    input  logic [15:0] in0_req_bits_user,
    output logic        in0_resp_valid,
    input  logic        in0_resp_ready,
    output logic [3:0]  in0_resp_bits_cmd,
    output logic [63:0] in0_resp_bits_rdata,
    output logic [15:0] in0_resp_bits_user,
    input  logic        in1_req_valid,
    output logic        in1_req_ready,
    input  logic [31:0] in1_req_bits_addr,
    input  logic [2:0]  in1_req_bits_size,
    input  logic [3:0]  in1_req_bits_cmd,
    input  logic [7:0]  in1_req_bits_wmask,
    input  logic [63:0] in1_req_bits_wdata,
    input  logic [15:0] in1_req_bits_user,
    output logic        in1_resp_valid,
    input  logic        in1_resp_ready,
    output logic [3:0]  in1_resp_bits_cmd,
    output logic [63:0] in1_resp_bits_rdata,
    output logic [15:0] in1_resp_bits_user,
    output logic        out_req_valid,
    input  logic        out_req_ready,
    output logic [31:0] out_req_bits_addr,
    output logic [2:0]  out_req_bits_size,
    output logic [3:0]  out_req_bits_cmd,
    output logic [7:0]  out_req_bits_wmask,
    output logic [63:0] out_req_bits_wdata,
    output logic [15:0] out_req_bits_user,
    input  logic        out_resp_valid,
    output logic        out_resp_ready,
    input  logic [3:0]  out_resp_bits_cmd,
    input  logic [63:0] out_resp_bits_rdata,
    input  logic [15:0] out_resp_bits_user
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, state_n;
    logic owner, last, idle, gnt1, take, sel0, sel1, resp_fire;
    // idle is masked by rst so no ready is offered while reset is held
    assign idle = state == IDLE && !rst;
    // in1 wins alone, or in round robin when in0 took the last grant
    assign gnt1 = in1_req_valid && (!in0_req_valid || (ARB_MODE == 0 && !last));
    assign in0_req_ready = idle && in0_req_valid && !gnt1;
    assign in1_req_ready = idle && gnt1;
    assign take = in0_req_ready || in1_req_ready;
    assign out_req_valid = state == REQ;
    assign sel0 = state == RESP && !owner;
    assign sel1 = state == RESP && owner;
    assign in0_resp_valid = sel0 && out_resp_valid;
    assign in1_resp_valid = sel1 && out_resp_valid;
    assign in0_resp_bits_cmd = sel0 ? out_resp_bits_cmd : '0;
    assign in0_resp_bits_rdata = sel0 ? out_resp_bits_rdata : '0;
    assign in0_resp_bits_user = sel0 ? out_resp_bits_user : '0;
    assign in1_resp_bits_cmd = sel1 ? out_resp_bits_cmd : '0;
    assign in1_resp_bits_rdata = sel1 ? out_resp_bits_rdata : '0;
    assign in1_resp_bits_user = sel1 ? out_resp_bits_user : '0;
    assign out_resp_ready = (sel0 && in0_resp_ready) || (sel1 && in1_resp_ready);
    assign resp_fire = out_resp_valid && out_resp_ready;
    always_comb begin
        state_n = state;
        if (state == IDLE && take) state_n = REQ;
        if (state == REQ && out_req_ready) state_n = RESP;
        if (state == RESP && resp_fire) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last <= 1'b1;
        end else begin
            state <= state_n;
            if (take) begin
                owner <= gnt1;
                last <= gnt1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_req_bits_addr <= '0;
            out_req_bits_size <= '0;
            out_req_bits_cmd <= '0;
            out_req_bits_wmask <= '0;
            out_req_bits_wdata <= '0;
            out_req_bits_user <= '0;
        end else if (take) begin
            out_req_bits_addr <= gnt1 ? in1_req_bits_addr : in0_req_bits_addr;
            out_req_bits_size <= gnt1 ? in1_req_bits_size : in0_req_bits_size;
            out_req_bits_cmd <= gnt1 ? in1_req_bits_cmd : in0_req_bits_cmd;
            out_req_bits_wmask <= gnt1 ? in1_req_bits_wmask : in0_req_bits_wmask;
            out_req_bits_wdata <= gnt1 ? in1_req_bits_wdata : in0_req_bits_wdata;
            out_req_bits_user <= gnt1 ? in1_req_bits_user : in0_req_bits_user;
        end
    end
endmodule

// File: tb/tb_simplebus_arb.sv
// tb_simplebus_arb: directed table and sequence checks of simplebus_arb in both arbitration modes
module tb_simplebus_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v0 = 1'b0, v1 = 1'b0, r0r = 1'b0, r1r = 1'b0, orr = 1'b0, orv = 1'b0;
    logic [31:0] a0 = 32'h1000, a1 = 32'h2000;
    logic [2:0] s0 = 3'd3, s1 = 3'd2;
    logic [3:0] c0 = 4'h1, c1 = 4'h0, oc = 4'h0;
    logic [7:0] m0 = 8'hff, m1 = 8'h0f;
    logic [63:0] d0 = 64'h0123, d1 = 64'h4567, od = 64'hdead;
    logic [15:0] u0 = 16'h0011, u1 = 16'h0022, ou = 16'h0033;
    logic r_i0rdy, r_i1rdy, r_i0rv, r_i1rv, r_oqv, r_ors;
    logic [3:0] r_i0c, r_i1c, r_oc;
    logic [63:0] r_i0d, r_i1d, r_od;
    logic [15:0] r_i0u, r_i1u, r_ou;
    logic [31:0] r_oa;
    logic [2:0] r_os;
    logic [7:0] r_om;
    logic f_i0rdy, f_i1rdy, f_i0rv, f_i1rv, f_oqv, f_ors;
    logic [3:0] f_i0c, f_i1c, f_oc;
    logic [63:0] f_i0d, f_i1d, f_od;
    logic [15:0] f_i0u, f_i1u, f_ou;
    logic [31:0] f_oa;
    logic [2:0] f_os;
    logic [7:0] f_om;
    int errors = 0, checks = 0;
    typedef struct {
        logic [3:0] in;
        logic [5:0] er;
        logic [1:0] ef;
        logic [31:0] ea;
    } vec_t;
    vec_t tv [12];
    always #5 clk = ~clk;
    simplebus_arb #(.ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .in0_req_valid(v0), .in0_req_ready(r_i0rdy), .in0_req_bits_addr(a0), .in0_req_bits_size(s0),
        .in0_req_bits_cmd(c0), .in0_req_bits_wmask(m0), .in0_req_bits_wdata(d0), .in0_req_bits_user(u0),
        .in0_resp_valid(r_i0rv), .in0_resp_ready(r0r), .in0_resp_bits_cmd(r_i0c), .in0_resp_bits_rdata(r_i0d), .in0_resp_bits_user(r_i0u),
        .in1_req_valid(v1), .in1_req_ready(r_i1rdy), .in1_req_bits_addr(a1), .in1_req_bits_size(s1),
        .in1_req_bits_cmd(c1), .in1_req_bits_wmask(m1), .in1_req_bits_wdata(d1), .in1_req_bits_user(u1),
        .in1_resp_valid(r_i1rv), .in1_resp_ready(r1r), .in1_resp_bits_cmd(r_i1c), .in1_resp_bits_rdata(r_i1d), .in1_resp_bits_user(r_i1u),
        .out_req_valid(r_oqv), .out_req_ready(orr), .out_req_bits_addr(r_oa), .out_req_bits_size(r_os),
        .out_req_bits_cmd(r_oc), .out_req_bits_wmask(r_om), .out_req_bits_wdata(r_od), .out_req_bits_user(r_ou),
        .out_resp_valid(orv), .out_resp_ready(r_ors), .out_resp_bits_cmd(oc), .out_resp_bits_rdata(od), .out_resp_bits_user(ou)
    );
    simplebus_arb #(.ARB_MODE(1)) u_fp (
        .clk(clk), .rst(rst),
        .in0_req_valid(v0), .in0_req_ready(f_i0rdy), .in0_req_bits_addr(a0), .in0_req_bits_size(s0),
        .in0_req_bits_cmd(c0), .in0_req_bits_wmask(m0), .in0_req_bits_wdata(d0), .in0_req_bits_user(u0),
        .in0_resp_valid(f_i0rv), .in0_resp_ready(r0r), .in0_resp_bits_cmd(f_i0c), .in0_resp_bits_rdata(f_i0d), .in0_resp_bits_user(f_i0u),
        .in1_req_valid(v1), .in1_req_ready(f_i1rdy), .in1_req_bits_addr(a1), .in1_req_bits_size(s1),
        .in1_req_bits_cmd(c1), .in1_req_bits_wmask(m1), .in1_req_bits_wdata(d1), .in1_req_bits_user(u1),
        .in1_resp_valid(f_i1rv), .in1_resp_ready(r1r), .in1_resp_bits_cmd(f_i1c), .in1_resp_bits_rdata(f_i1d), .in1_resp_bits_user(f_i1u),
        .out_req_valid(f_oqv), .out_req_ready(orr), .out_req_bits_addr(f_oa), .out_req_bits_size(f_os),
        .out_req_bits_cmd(f_oc), .out_req_bits_wmask(f_om), .out_req_bits_wdata(f_od), .out_req_bits_user(f_ou),
        .out_resp_valid(orv), .out_resp_ready(f_ors), .out_resp_bits_cmd(oc), .out_resp_bits_rdata(od), .out_resp_bits_user(ou)
    );
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    initial begin
        // {v0,v1,out_req_ready,out_resp_valid}; rr {i0rdy,i1rdy,oqv,ors,i0rv,i1rv}; fp {i0rdy,i1rdy}; rr out addr
        tv[0]  = '{4'hf, 6'b100000, 2'b10, 32'h0};
        tv[1]  = '{4'hf, 6'b001000, 2'b00, 32'h1000};
        tv[2]  = '{4'hf, 6'b000110, 2'b00, 32'h1000};
        tv[3]  = '{4'hf, 6'b010000, 2'b10, 32'h1000};
        tv[4]  = '{4'hf, 6'b001000, 2'b00, 32'h2000};
        tv[5]  = '{4'hf, 6'b000101, 2'b00, 32'h2000};
        tv[6]  = '{4'hf, 6'b100000, 2'b10, 32'h2000};
        tv[7]  = '{4'hf, 6'b001000, 2'b00, 32'h1000};
        tv[8]  = '{4'hf, 6'b000110, 2'b00, 32'h1000};
        tv[9]  = '{4'hf, 6'b010000, 2'b10, 32'h1000};
        tv[10] = '{4'hf, 6'b001000, 2'b00, 32'h2000};
        tv[11] = '{4'hf, 6'b000101, 2'b00, 32'h2000};
        v0 = 1'b1; v1 = 1'b1; orv = 1'b1; r0r = 1'b1; r1r = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_rr_ctl", {r_i0rdy, r_i1rdy, r_oqv, r_ors, r_i0rv, r_i1rv}, 0);
        chk("reset_fp_ctl", {f_i0rdy, f_i1rdy, f_oqv, f_ors, f_i0rv, f_i1rv}, 0);
        chk("reset_addr", r_oa, 0);
        chk("reset_user", r_ou, 0);
        @(negedge clk);
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; orv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            {v0, v1, orr, orv} = tv[i].in;
            #2;
            chk($sformatf("rr_vec%0d", i), {r_i0rdy, r_i1rdy, r_oqv, r_ors, r_i0rv, r_i1rv}, tv[i].er);
            chk($sformatf("fp_vec%0d", i), {f_i0rdy, f_i1rdy}, tv[i].ef);
            chk($sformatf("addr_vec%0d", i), r_oa, tv[i].ea);
        end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b1; orr = 1'b0; orv = 1'b0;
        a1 = 32'h80001000; c1 = 4'h0; u1 = 16'h00AB;
        #2;
        chk("rd_grant1", r_i1rdy, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v1 = 1'b0; a1 = 32'h0; u1 = 16'h0; c1 = 4'h7; orr = (k == 3);
            #2;
            chk($sformatf("rd_hold_valid%0d", k), r_oqv, 1);
            chk($sformatf("rd_hold_addr%0d", k), r_oa, 32'h80001000);
            chk($sformatf("rd_hold_user%0d", k), r_ou, 16'h00AB);
            chk($sformatf("rd_hold_cmd%0d", k), r_oc, 4'h0);
        end
        @(negedge clk);
        orr = 1'b0; orv = 1'b1; od = 64'h1122334455667788; ou = 16'h00AB; oc = 4'h0;
        #2;
        chk("rd_in1_valid", r_i1rv, 1);
        chk("rd_in1_rdata", r_i1d, 64'h1122334455667788);
        chk("rd_in1_user", r_i1u, 16'h00AB);
        chk("rd_in0_valid", r_i0rv, 0);
        chk("rd_in0_rdata", r_i0d, 0);
        chk("rd_in0_user", r_i0u, 0);
        @(negedge clk);
        #2;
        chk("idle_resp_ready", r_ors, 0);
        chk("idle_in0_rv", r_i0rv, 0);
        chk("idle_in1_rv", r_i1rv, 0);
        @(negedge clk);
        orv = 1'b0; v0 = 1'b1; a0 = 32'h3000;
        #2;
        chk("bp_grant0", r_i0rdy, 1);
        @(negedge clk);
        v0 = 1'b0; orr = 1'b1;
        #2;
        chk("bp_req_valid", r_oqv, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            orr = 1'b0; orv = 1'b1; r0r = 1'b0;
            #2;
            chk($sformatf("bp_ors%0d", k), r_ors, 0);
            chk($sformatf("bp_in_resp%0d", k), r_i0rv, 1);
        end
        @(negedge clk);
        r0r = 1'b1;
        #2;
        chk("bp_release", r_ors, 1);
        @(negedge clk);
        #2;
        chk("bp_done_rv", r_i0rv, 0);
        chk("bp_done_ors", r_ors, 0);
        @(negedge clk);
        orv = 1'b0; v0 = 1'b1; a0 = 32'h4000; a1 = 32'h5000;
        #2;
        chk("rst_grant0", r_i0rdy, 1);
        @(negedge clk);
        v0 = 1'b0; orr = 1'b0;
        #2;
        chk("rst_in_req", r_oqv, 1);
        v1 = 1'b1; orv = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_async_ctl", {r_i0rdy, r_i1rdy, r_oqv, r_ors, r_i0rv, r_i1rv}, 0);
        chk("rst_async_addr", r_oa, 0);
        @(negedge clk);
        rst = 1'b0; orv = 1'b0;
        #2;
        chk("rst_after_grant", r_i1rdy, 1);
        @(negedge clk);
        v1 = 1'b0;
        #2;
        chk("rst_after_req", r_oqv, 1);
        chk("rst_after_addr", r_oa, 32'h5000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
